mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the hart's single `memory` block between the instruction-fetch path and the load/store path. It accepts at most one request per cycle using round-robin priority and issues it to `memory`. Because `memory` has a one-cycle registered read, the arbiter tracks which requester owns the outstanding access and routes `mem_rdata` back to that requester in the following cycle. It sits between the hart's fetch/execute logic and `memory`.

## Interface
- XLEN, 32: address/data width; must match `isa_types::XLEN`.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request; held with `fetch_addr` stable until accepted.
- fetch_addr  in  XLEN  fetch byte address.
- fetch_ready  out  1  combinational; fetch accepted this cycle (`fetch_req & fetch_ready`).
- fetch_rvalid  out  1  registered; fetch response valid.
- fetch_rdata  out  XLEN  fetch data; valid only with `fetch_rvalid`.
- fetch_err  out  1  registered; set with `fetch_rvalid` when the request was misaligned.
- data_req  in  1  load/store request; held stable until accepted.
- data_addr  in  XLEN  load/store byte address.
- data_wenable  in  1  1 = store, 0 = load.
- data_wwidth  in  write_width_t  store width.
- data_wdata  in  XLEN  store data.
- data_ready  out  1  combinational; data request accepted this cycle.
- data_rvalid  out  1  registered; load data or store acknowledge valid.
- data_rdata  out  XLEN  load data; 0 for store acknowledges.
- mem_addr  out  XLEN  to `memory.addr`.
- mem_wwidth  out  write_width_t  to `memory.wwidth`; always equals `data_wwidth`.
- mem_wenable  out  1  to `memory.wenable`.
- mem_wdata  out  XLEN  to `memory.wdata`; always equals `data_wdata`.
- mem_rdata  in  XLEN  from `memory.rdata`; valid one cycle after its address is presented.

## Operation
- **Grant (combinational, every cycle, reset low):**
  - Only fetch requesting: grant fetch.
  - Only data requesting: grant data.
  - Both requesting: grant the port that is not `last_grant`.
  - Neither requesting: no grant; `mem_wenable = 0`, `mem_addr = 0`.
- **`last_grant` register:** reset value FETCH, so data wins the first tie. Updated on every grant, including misaligned fetches.
- **Mux:**
  - Fetch granted: `mem_addr = fetch_addr`, `mem_wenable = 0`.
  - Data granted: `mem_addr = data_addr`, `mem_wenable = data_wenable`.
- **Misaligned fetch (`fetch_addr[1:0] != 0`):**
  - Accepted and granted normally (`fetch_ready = 1`); `mem_addr` is still driven.
  - Next cycle: `fetch_rvalid = 1`, `fetch_err = 1`, `fetch_rdata = 0`.
  - Memory map for reference: ROM at 0x000–0x7ff is word-read only; RAM at 0x800–0xbff.
- **Response-owner register `resp_owner`:** states NONE, FETCH, FETCH_ERR, DATA_LD, DATA_ST. Loaded each cycle from the current grant; NONE if there is no grant.
- **Responses (driven from `resp_owner`):**
  - FETCH: `fetch_rvalid = 1`, `fetch_rdata = mem_rdata`.
  - FETCH_ERR: as described under misaligned fetch.
  - DATA_LD: `data_rvalid = 1`, `data_rdata = mem_rdata`.
  - DATA_ST: `data_rvalid = 1`, `data_rdata = 0`.
  - NONE: all rvalid/err outputs 0, all rdata outputs 0.
- **Pipelining:** a new request may be accepted in the same cycle as a response. Back-to-back accepts are allowed, one per cycle, with no bubble.
- A requester that is not granted sees `ready = 0`, must hold its request, and keeps losing only while the other port wins ties alternately. Maximum wait under contention: 1 cycle.

## Timing
- **Reset (asynchronous):**
  - `resp_owner = NONE`, `last_grant = FETCH`.
  - All rvalid, err and rdata outputs = 0.
  - While reset is high: ready outputs = 0, `mem_wenable = 0`, `mem_addr = 0`.
- **Reset mid-operation:** the outstanding response is discarded; no rvalid appears after reset deasserts.
- **Latency:** request accepted at edge N produces its response in cycle N+1, i.e. after exactly one edge.
- Store takes effect at the accept edge; the acknowledge follows one cycle later.
- Ready outputs have a combinational path from req inputs. rvalid outputs are registered; rdata outputs come combinationally from `mem_rdata` gated by `resp_owner`.

## Test plan
- Single fetch to 0x004 (ROM word 1 = 0x00500093) -> `fetch_ready` in cycle 0; `fetch_rvalid = 1`, `fetch_rdata = 0x00500093` in cycle 1; `data_rvalid` stays 0.
- Store 0xDEADBEEF word to 0x800, then load from 0x800 in the next cycle -> `data_rvalid` in cycles 1 and 2; cycle 2 `data_rdata = 0xDEADBEEF`; cycle 1 `data_rdata = 0`.
- Both ports held requesting for 4 cycles after reset -> grant order data, fetch, data, fetch; responses alternate one cycle later.
- Fetch at 0x006 -> accepted; next cycle `fetch_err = 1`, `fetch_rdata = 0`; no `mem_wenable` pulse.
- Assert reset in the cycle after a load is accepted -> `data_rvalid` = 0 during and after reset; first post-reset tie is granted to data.
- Idle with both req low -> `mem_wenable = 0`, `mem_addr = 0`, all rvalid 0 for 10 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous memory between
// fetch and load/store; routes the one-cycle-late read data to its owner.
//
// Ports:
//   clock, reset                : clock, async active-high reset
//   fetch_req/addr/ready        : fetch request handshake
//   fetch_rvalid/rdata/err      : fetch response (err on misaligned address)
//   data_req/addr/wenable/...   : load/store request handshake
//   data_rvalid/rdata           : load data or store acknowledge
//   mem_*                       : memory block address/write/read lines

package isa_types;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WW_BYTE = 2'd0,
    WW_HALF = 2'd1,
    WW_WORD = 2'd2
  } write_width_t;
endpackage

module mem_arbiter
  import isa_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            fetch_ready,
  output logic            fetch_rvalid,
  output logic [XLEN-1:0] fetch_rdata,
  output logic            fetch_err,
  input  logic            data_req,
  input  logic [XLEN-1:0] data_addr,
  input  logic            data_wenable,
  input  write_width_t    data_wwidth,
  input  logic [XLEN-1:0] data_wdata,
  output logic            data_ready,
  output logic            data_rvalid,
  output logic [XLEN-1:0] data_rdata,
  output logic [XLEN-1:0] mem_addr,
  output write_width_t    mem_wwidth,
  output logic            mem_wenable,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic {
    LG_FETCH = 1'b0,
    LG_DATA  = 1'b1
  } last_t;

  typedef enum logic [2:0] {
    RO_NONE      = 3'd0,
    RO_FETCH     = 3'd1,
    RO_FETCH_ERR = 3'd2,
    RO_DATA_LD   = 3'd3,
    RO_DATA_ST   = 3'd4
  } owner_t;

  last_t  last_grant, last_next;
  owner_t resp_owner, owner_next;

  logic grant_fetch;
  logic grant_data;
  logic fetch_misaligned;

  assign fetch_misaligned = fetch_addr[1:0] != 2'b00;

  // On a tie, the port that did not win last time goes first.
  assign grant_fetch = !reset && fetch_req &&
                       (!data_req || last_grant == LG_DATA);
  assign grant_data  = !reset && data_req &&
                       (!fetch_req || last_grant == LG_FETCH);

  assign fetch_ready = grant_fetch;
  assign data_ready  = grant_data;
  assign mem_wwidth  = data_wwidth;
  assign mem_wdata   = data_wdata;

  always_comb begin
    mem_addr    = '0;
    mem_wenable = 1'b0;
    owner_next  = RO_NONE;
    last_next   = last_grant;
    unique case (1'b1)
      grant_fetch: begin
        mem_addr   = fetch_addr;
        last_next  = LG_FETCH;
        owner_next = fetch_misaligned ? RO_FETCH_ERR : RO_FETCH;
      end
      grant_data: begin
        mem_addr    = data_addr;
        mem_wenable = data_wenable;
        last_next   = LG_DATA;
        owner_next  = data_wenable ? RO_DATA_ST : RO_DATA_LD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_owner <= RO_NONE;
      last_grant <= LG_FETCH;
    end else begin
      resp_owner <= owner_next;
      last_grant <= last_next;
    end
  end

  // Read data is steered combinationally; validity comes from the register.
  always_comb begin
    fetch_rvalid = 1'b0;
    fetch_err    = 1'b0;
    fetch_rdata  = '0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    unique case (resp_owner)
      RO_FETCH: begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = mem_rdata;
      end
      RO_FETCH_ERR: begin
        fetch_rvalid = 1'b1;
        fetch_err    = 1'b1;
      end
      RO_DATA_LD: begin
        data_rvalid = 1'b1;
        data_rdata  = mem_rdata;
      end
      RO_DATA_ST: begin
        data_rvalid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small
// one-cycle registered memory model (ROM word 1 preloaded).
module tb_mem_arbiter;
  import isa_types::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = '0;
  logic         fetch_ready;
  logic         fetch_rvalid;
  logic [31:0]  fetch_rdata;
  logic         fetch_err;
  logic         data_req = 1'b0;
  logic [31:0]  data_addr = '0;
  logic         data_wenable = 1'b0;
  write_width_t data_wwidth = WW_WORD;
  logic [31:0]  data_wdata = '0;
  logic         data_ready;
  logic         data_rvalid;
  logic [31:0]  data_rdata;
  logic [31:0]  mem_addr;
  write_width_t mem_wwidth;
  logic         mem_wenable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem_arr [0:1023];

  mem_arbiter #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .data_req(data_req), .data_addr(data_addr),
    .data_wenable(data_wenable), .data_wwidth(data_wwidth),
    .data_wdata(data_wdata), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth),
    .mem_wenable(mem_wenable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wenable) mem_arr[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
    mem_arr[1] = 32'h0050_0093;

    // Reset state, with requests pending
    fetch_req = 1'b1; fetch_addr = 32'h4;
    data_req = 1'b1; data_addr = 32'h800;
    settle();
    chk("rst_fready", {31'b0, fetch_ready}, 0);
    chk("rst_dready", {31'b0, data_ready}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwen", {31'b0, mem_wenable}, 0);
    chk("rst_frv", {31'b0, fetch_rvalid}, 0);
    chk("rst_drv", {31'b0, data_rvalid}, 0);
    data_req = 1'b0;
    step();
    reset = 1'b0;

    // Single fetch to 0x004
    fetch_req = 1'b1; fetch_addr = 32'h4;
    settle();
    chk("f1_ready", {31'b0, fetch_ready}, 1);
    chk("f1_dready", {31'b0, data_ready}, 0);
    chk("f1_maddr", mem_addr, 32'h4);
    step();
    fetch_req = 1'b0;
    settle();
    chk("f1_rvalid", {31'b0, fetch_rvalid}, 1);
    chk("f1_rdata", fetch_rdata, 32'h0050_0093);
    chk("f1_err", {31'b0, fetch_err}, 0);
    chk("f1_drv", {31'b0, data_rvalid}, 0);

    // Store then load at 0x800
    data_req = 1'b1; data_addr = 32'h800; data_wenable = 1'b1;
    data_wdata = 32'hDEAD_BEEF; data_wwidth = WW_WORD;
    settle();
    chk("st_ready", {31'b0, data_ready}, 1);
    chk("st_mwen", {31'b0, mem_wenable}, 1);
    chk("st_maddr", mem_addr, 32'h800);
    chk("st_mwdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mwidth", {30'b0, mem_wwidth}, {30'b0, WW_WORD});
    step();
    data_wenable = 1'b0;
    settle();
    chk("ld_ready", {31'b0, data_ready}, 1);
    chk("ld_mwen", {31'b0, mem_wenable}, 0);
    chk("st_ack", {31'b0, data_rvalid}, 1);
    chk("st_ack_data", data_rdata, 0);
    chk("st_frv", {31'b0, fetch_rvalid}, 0);
    step();
    data_req = 1'b0;
    settle();
    chk("ld_rvalid", {31'b0, data_rvalid}, 1);
    chk("ld_rdata", data_rdata, 32'hDEAD_BEEF);

    // Contention after reset: data, fetch, data, fetch
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    data_req = 1'b1; data_addr = 32'h800;
    settle();
    chk("rr0_d", {31'b0, data_ready}, 1);
    chk("rr0_f", {31'b0, fetch_ready}, 0);
    chk("rr0_addr", mem_addr, 32'h800);
    step();
    settle();
    chk("rr1_f", {31'b0, fetch_ready}, 1);
    chk("rr1_d", {31'b0, data_ready}, 0);
    chk("rr1_drv", {31'b0, data_rvalid}, 1);
    chk("rr1_drd", data_rdata, 32'hDEAD_BEEF);
    step();
    settle();
    chk("rr2_d", {31'b0, data_ready}, 1);
    chk("rr2_frv", {31'b0, fetch_rvalid}, 1);
    chk("rr2_frd", fetch_rdata, 32'h0050_0093);
    chk("rr2_drv", {31'b0, data_rvalid}, 0);
    step();
    settle();
    chk("rr3_f", {31'b0, fetch_ready}, 1);
    chk("rr3_drv", {31'b0, data_rvalid}, 1);
    step();
    fetch_req = 1'b0; data_req = 1'b0;
    settle();
    chk("rr4_frv", {31'b0, fetch_rvalid}, 1);
    chk("rr4_drv", {31'b0, data_rvalid}, 0);

    // Misaligned fetch at 0x006
    fetch_req = 1'b1; fetch_addr = 32'h6;
    settle();
    chk("mis_ready", {31'b0, fetch_ready}, 1);
    chk("mis_maddr", mem_addr, 32'h6);
    chk("mis_mwen", {31'b0, mem_wenable}, 0);
    step();
    fetch_req = 1'b0;
    settle();
    chk("mis_rvalid", {31'b0, fetch_rvalid}, 1);
    chk("mis_err", {31'b0, fetch_err}, 1);
    chk("mis_rdata", fetch_rdata, 0);
    chk("mis_mwen2", {31'b0, mem_wenable}, 0);

    // Reset right after a load is accepted
    data_req = 1'b1; data_addr = 32'h800;
    settle();
    chk("rl_ready", {31'b0, data_ready}, 1);
    step();
    data_req = 1'b0;
    reset = 1'b1;
    settle();
    chk("rl_drv_rst", {31'b0, data_rvalid}, 0);
    chk("rl_rdata_rst", data_rdata, 0);
    step();
    reset = 1'b0;
    settle();
    chk("rl_drv_post", {31'b0, data_rvalid}, 0);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    data_req = 1'b1; data_addr = 32'h800;
    settle();
    chk("rl_tie_d", {31'b0, data_ready}, 1);
    chk("rl_tie_f", {31'b0, fetch_ready}, 0);
    step();
    fetch_req = 1'b0; data_req = 1'b0;
    step();

    // Idle
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_mwen", {31'b0, mem_wenable}, 0);
      chk("idle_maddr", mem_addr, 0);
      chk("idle_rv", {30'b0, fetch_rvalid, data_rvalid}, 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
